// File: rtl/data_memory_bus_if.sv
// Load/store request and single-beat response bus between a client (master) and data_memory_bus (slave).
// Requests use a valid/ready handshake; responses are a one-cycle valid pulse with no back-pressure.
interface data_memory_bus_if;
  logic        req_valid;
  logic        req_ready;
  logic        mem_write;
  logic [31:0] address;
  logic [1:0]  size;
  logic        unsigned_load;
  logic [31:0] write_data;
  logic        resp_valid;
  logic [31:0] read_data;
  logic        error;

  modport master (
    output req_valid, mem_write, address, size, unsigned_load, write_data,
    input  req_ready, resp_valid, read_data, error
  );

  modport slave (
    input  req_valid, mem_write, address, size, unsigned_load, write_data,
    output req_ready, resp_valid, read_data, error
  );
endinterface

// File: rtl/data_memory_bus.sv
// Byte/half/word data memory, one request in flight; response WAIT_STATES+1 cycles after acceptance (1 for rejects).
// req_ready is high only while idle; the one-cycle response pulse cannot be stalled.
module data_memory_bus #(
  parameter int unsigned MEMORY_DEPTH = 1024,
  parameter int unsigned WAIT_STATES  = 1,
  parameter logic [31:0] BASE_ADDRESS = 32'h1001_0000
) (
  input logic              clk,
  input logic              reset,
  data_memory_bus_if.slave bus
);
  localparam int unsigned AW   = $clog2(MEMORY_DEPTH);
  localparam logic [31:0] SPAN = 32'(MEMORY_DEPTH * 4);
  localparam logic [3:0]  WS   = 4'(WAIT_STATES);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t        state, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [AW-1:0] idx_q;
  logic [1:0]    lane_q, size_q;
  logic          write_q, uns_q, err_q;
  logic [31:0]   wdata_q, rdata_q;

  logic [31:0]   mem [MEMORY_DEPTH];

  logic [31:0]   offset;
  logic          req_err, accept, commit, in_idle;
  logic [AW-1:0] eff_idx;
  logic [1:0]    eff_lane, eff_size;
  logic          eff_write, eff_uns;
  logic [31:0]   eff_wdata, cur_word, load_val, store_word;
  logic [7:0]    sel_byte;
  logic [15:0]   sel_half;

  assign offset  = bus.address - BASE_ADDRESS;
  assign in_idle = (state == IDLE);

  always_comb begin
    req_err = 1'b0;
    case (bus.size)
      2'b01:   req_err = bus.address[0];
      2'b10:   req_err = |bus.address[1:0];
      2'b11:   req_err = 1'b1;
      default: req_err = 1'b0;
    endcase
    if ((bus.address < BASE_ADDRESS) || (offset >= SPAN)) req_err = 1'b1;
  end

  assign bus.req_ready = in_idle;
  assign accept        = bus.req_valid && in_idle;

  // With zero wait states the access completes on the acceptance edge, so operands come straight off the bus.
  assign eff_idx   = in_idle ? offset[AW+1:2]    : idx_q;
  assign eff_lane  = in_idle ? bus.address[1:0]  : lane_q;
  assign eff_size  = in_idle ? bus.size          : size_q;
  assign eff_write = in_idle ? bus.mem_write     : write_q;
  assign eff_uns   = in_idle ? bus.unsigned_load : uns_q;
  assign eff_wdata = in_idle ? bus.write_data    : wdata_q;

  // Gating with reset keeps a request seen during reset from touching the array.
  assign commit = reset && ((accept && !req_err && (WS == 4'd0)) ||
                            ((state == WAIT) && (cnt_q <= 4'd1)));

  assign cur_word = mem[eff_idx];

  always_comb begin
    case (eff_lane)
      2'd0:    sel_byte = cur_word[7:0];
      2'd1:    sel_byte = cur_word[15:8];
      2'd2:    sel_byte = cur_word[23:16];
      default: sel_byte = cur_word[31:24];
    endcase
    sel_half = eff_lane[1] ? cur_word[31:16] : cur_word[15:0];

    case (eff_size)
      2'b00:   load_val = eff_uns ? {24'd0, sel_byte} : {{24{sel_byte[7]}}, sel_byte};
      2'b01:   load_val = eff_uns ? {16'd0, sel_half} : {{16{sel_half[15]}}, sel_half};
      default: load_val = cur_word;
    endcase

    store_word = cur_word;
    case (eff_size)
      2'b00:   store_word[{eff_lane, 3'b000} +: 8]       = eff_wdata[7:0];
      2'b01:   store_word[{eff_lane[1], 4'b0000} +: 16]  = eff_wdata[15:0];
      default: store_word = eff_wdata;
    endcase
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt_q;
    case (state)
      IDLE: begin
        if (accept) begin
          if (req_err || (WS == 4'd0)) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = WS;
          end
        end
      end
      WAIT: begin
        if (cnt_q <= 4'd1) begin
          state_d = RESP;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      lane_q  <= 2'd0;
      size_q  <= 2'd0;
      write_q <= 1'b0;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
    end else begin
      state <= state_d;
      cnt_q <= cnt_d;
      if (accept) begin
        idx_q   <= offset[AW+1:2];
        lane_q  <= bus.address[1:0];
        size_q  <= bus.size;
        write_q <= bus.mem_write;
        uns_q   <= bus.unsigned_load;
        wdata_q <= bus.write_data;
        err_q   <= req_err;
        rdata_q <= 32'd0;
      end
      if (commit) rdata_q <= eff_write ? 32'd0 : load_val;
    end
  end

  // Storage is deliberately outside the reset domain so contents survive reset.
  always_ff @(posedge clk) begin
    if (commit && eff_write) mem[eff_idx] <= store_word;
  end

  assign bus.resp_valid = (state == RESP);
  assign bus.read_data  = (state == RESP) ? rdata_q : 32'd0;
  assign bus.error      = (state == RESP) && err_q;
endmodule

// File: tb/tb_data_memory_bus.sv
// Table-driven load/store vectors with a response scoreboard, plus reset-abort and streaming sequences.
module tb_data_memory_bus;
  localparam logic [31:0] BASE = 32'h1001_0000;
  localparam logic [1:0]  SB = 2'b00, SH = 2'b01, SW = 2'b10, SR = 2'b11;
  localparam int          NV = 30;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  data_memory_bus_if bus_if();

  data_memory_bus #(.MEMORY_DEPTH(1024), .WAIT_STATES(2), .BASE_ADDRESS(BASE)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_if)
  );

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic        uns;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic [31:0] rd;
    logic        err;
    int          acc;
    int          lat;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  vec_t vecs[NV];
  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   idle_viol = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Latency is counted so that a response in the cycle right after the acceptance edge is 1.
  always @(negedge clk) begin
    if (bus_if.resp_valid) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_resp: got resp_valid=1 expected no response (cycle %0d)", cyc);
      end else begin
        mon_e = sb.pop_front();
        check("read_data", bus_if.read_data, mon_e.rd);
        check("error", {31'd0, bus_if.error}, {31'd0, mon_e.err});
        check("latency", 32'(cyc - mon_e.acc + 1), 32'(mon_e.lat));
      end
    end else if (bus_if.read_data !== 32'd0 || bus_if.error !== 1'b0) begin
      idle_viol++;
    end
  end

  task automatic drain();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 40) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL resp_timeout: got %0d pending responses expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic drive(input vec_t v);
    bus_if.mem_write     = v.wr;
    bus_if.size          = v.size;
    bus_if.address       = v.addr;
    bus_if.unsigned_load = v.uns;
    bus_if.write_data    = v.wdata;
  endtask

  task automatic issue(input vec_t v);
    int t;
    drive(v);
    bus_if.req_valid = 1'b1;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!bus_if.req_ready && t < 50);
    if (!bus_if.req_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout: got req_ready=0 expected 1 within 50 cycles");
      bus_if.req_valid = 1'b0;
      return;
    end
    sb.push_back('{rd: v.exp_rd, err: v.exp_err, acc: cyc + 1, lat: (v.exp_err ? 1 : 3)});
    @(posedge clk);
    #1 bus_if.req_valid = 1'b0;
    drain();
  endtask

  initial begin
    vec_t v;
    int   resp_cnt;
    int   accs[$];

    vecs[0]  = '{1'b1, SW, BASE + 32'h004, 1'b0, 32'h8899_AABB, 32'h0000_0000, 1'b0};
    vecs[1]  = '{1'b0, SW, BASE + 32'h004, 1'b0, 32'h0,         32'h8899_AABB, 1'b0};
    vecs[2]  = '{1'b0, SB, BASE + 32'h004, 1'b0, 32'h0,         32'hFFFF_FFBB, 1'b0};
    vecs[3]  = '{1'b0, SB, BASE + 32'h006, 1'b1, 32'h0,         32'h0000_0099, 1'b0};
    vecs[4]  = '{1'b0, SB, BASE + 32'h005, 1'b0, 32'h0,         32'hFFFF_FFAA, 1'b0};
    vecs[5]  = '{1'b0, SH, BASE + 32'h006, 1'b0, 32'h0,         32'hFFFF_8899, 1'b0};
    vecs[6]  = '{1'b0, SH, BASE + 32'h004, 1'b1, 32'h0,         32'h0000_AABB, 1'b0};
    vecs[7]  = '{1'b1, SH, BASE + 32'h006, 1'b0, 32'hDEAD_1234, 32'h0000_0000, 1'b0};
    vecs[8]  = '{1'b0, SW, BASE + 32'h004, 1'b0, 32'h0,         32'h1234_AABB, 1'b0};
    vecs[9]  = '{1'b0, SW, BASE + 32'h002, 1'b0, 32'h0,         32'h0000_0000, 1'b1};
    vecs[10] = '{1'b0, SB, 32'h1000_FFFF,  1'b0, 32'h0,         32'h0000_0000, 1'b1};
    vecs[11] = '{1'b1, SW, BASE + 32'h003, 1'b0, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1};
    vecs[12] = '{1'b1, SR, BASE + 32'h004, 1'b0, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1};
    vecs[13] = '{1'b1, SH, BASE + 32'h005, 1'b0, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1};
    vecs[14] = '{1'b0, SW, BASE + 32'h004, 1'b1, 32'h0,         32'h1234_AABB, 1'b0};
    vecs[15] = '{1'b1, SW, BASE + 32'hFFC, 1'b0, 32'h1122_3344, 32'h0000_0000, 1'b0};
    vecs[16] = '{1'b1, SB, BASE + 32'hFFF, 1'b0, 32'h7777_77A5, 32'h0000_0000, 1'b0};
    vecs[17] = '{1'b0, SW, BASE + 32'hFFC, 1'b0, 32'h0,         32'hA522_3344, 1'b0};
    vecs[18] = '{1'b0, SB, BASE + 32'hFFF, 1'b0, 32'h0,         32'hFFFF_FFA5, 1'b0};
    vecs[19] = '{1'b0, SB, BASE + 32'h1000, 1'b0, 32'h0,        32'h0000_0000, 1'b1};
    vecs[20] = '{1'b1, SB, BASE + 32'h000, 1'b0, 32'h1234_5680, 32'h0000_0000, 1'b0};
    vecs[21] = '{1'b0, SB, BASE + 32'h000, 1'b1, 32'h0,         32'h0000_0080, 1'b0};
    vecs[22] = '{1'b1, SW, BASE + 32'h1000, 1'b0, 32'h0,        32'h0000_0000, 1'b1};
    vecs[23] = '{1'b0, SB, BASE + 32'h000, 1'b0, 32'h0,         32'hFFFF_FF80, 1'b0};
    vecs[24] = '{1'b1, SH, BASE + 32'hFFC, 1'b0, 32'h0000_BEEF, 32'h0000_0000, 1'b0};
    vecs[25] = '{1'b0, SW, BASE + 32'hFFC, 1'b0, 32'h0,         32'hA522_BEEF, 1'b0};
    vecs[26] = '{1'b0, SH, BASE + 32'hFFE, 1'b1, 32'h0,         32'h0000_A522, 1'b0};
    vecs[27] = '{1'b0, SH, BASE + 32'hFFC, 1'b0, 32'h0,         32'hFFFF_BEEF, 1'b0};
    vecs[28] = '{1'b1, SB, BASE + 32'hFFD, 1'b0, 32'h0000_003C, 32'h0000_0000, 1'b0};
    vecs[29] = '{1'b0, SW, BASE + 32'hFFC, 1'b0, 32'h0,         32'hA522_3CEF, 1'b0};

    bus_if.req_valid     = 1'b0;
    bus_if.mem_write     = 1'b0;
    bus_if.address       = 32'd0;
    bus_if.size          = 2'b00;
    bus_if.unsigned_load = 1'b0;
    bus_if.write_data    = 32'd0;

    repeat (3) @(negedge clk);
    check("rst_resp_valid", {31'd0, bus_if.resp_valid}, 32'd0);
    check("rst_read_data", bus_if.read_data, 32'd0);
    check("rst_error", {31'd0, bus_if.error}, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    check("rst_req_ready", {31'd0, bus_if.req_ready}, 32'd1);
    @(posedge clk);
    #1;

    for (int i = 0; i < NV; i++) issue(vecs[i]);

    // Store abandoned by reset while waiting: no response, memory keeps 32'h1234_AABB.
    v = '{1'b1, SW, BASE + 32'h004, 1'b0, 32'hCAFE_F00D, 32'h0, 1'b0};
    drive(v);
    bus_if.req_valid = 1'b1;
    @(negedge clk);
    check("abort_ready_before", {31'd0, bus_if.req_ready}, 32'd1);
    @(posedge clk);
    #1 bus_if.req_valid = 1'b0;
    @(negedge clk);
    check("abort_busy_in_wait", {31'd0, bus_if.req_ready}, 32'd0);
    reset = 1'b0;
    #1;
    check("abort_rst_resp_valid", {31'd0, bus_if.resp_valid}, 32'd0);
    check("abort_rst_read_data", bus_if.read_data, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    resp_cnt = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus_if.resp_valid) resp_cnt++;
    end
    check("abort_no_resp", 32'(resp_cnt), 32'd0);
    check("abort_ready_after", {31'd0, bus_if.req_ready}, 32'd1);
    @(posedge clk);
    #1;
    issue('{1'b0, SW, BASE + 32'h004, 1'b0, 32'h0, 32'h1234_AABB, 1'b0});

    // req_valid held high: one acceptance every WAIT_STATES+2 cycles.
    v = '{1'b0, SB, BASE + 32'h007, 1'b1, 32'h0, 32'h0000_0012, 1'b0};
    drive(v);
    bus_if.req_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus_if.req_ready) begin
        sb.push_back('{rd: v.exp_rd, err: 1'b0, acc: cyc + 1, lat: 3});
        accs.push_back(cyc + 1);
      end
    end
    @(posedge clk);
    #1 bus_if.req_valid = 1'b0;
    drain();
    check("stream_accepts", 32'(accs.size()), 32'd5);
    for (int i = 1; i < accs.size(); i++) check("stream_gap", 32'(accs[i] - accs[i-1]), 32'd4);

    check("outputs_zero_when_no_resp", 32'(idle_viol), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
